// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - 7-segment bus receiver: glitch filter, hex decode, valid/ready event output
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_2,
    input  logic       reset_n,
    input  logic [7:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] digit,
    output logic       dp,
    output logic       err,
    output logic       overrun,
    output logic [7:0] evt_count
);
    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_last_acc;
    logic [3:0]       r_digit;
    logic             r_dp;
    logic             r_err;
    logic             r_overrun;
    logic [7:0]       r_evt_count;

    logic             w_stable;
    logic             w_commit;
    logic             w_blank;
    logic             w_event;
    logic             w_hex_ok;
    logic [3:0]       w_hex_val;
    logic             w_load;
    logic             w_handshake;
    logic             w_drop;

    assign w_stable = (seg_in == r_cand) && (r_cnt == CNT_MAX);
    assign w_commit = w_stable && (r_cand != r_last_acc);
    assign w_blank  = (r_cand[6:0] == 7'h00);
    assign w_event  = w_commit && !w_blank;

    always_comb begin
        w_hex_ok  = 1'b1;
        w_hex_val = 4'h0;
        case (r_cand[6:0])
            7'h3F: w_hex_val = 4'h0;
            7'h06: w_hex_val = 4'h1;
            7'h5B: w_hex_val = 4'h2;
            7'h4F: w_hex_val = 4'h3;
            7'h66: w_hex_val = 4'h4;
            7'h6D: w_hex_val = 4'h5;
            7'h7D: w_hex_val = 4'h6;
            7'h07: w_hex_val = 4'h7;
            7'h7F: w_hex_val = 4'h8;
            7'h6F: w_hex_val = 4'h9;
            7'h77: w_hex_val = 4'hA;
            7'h7C: w_hex_val = 4'hB;
            7'h39: w_hex_val = 4'hC;
            7'h5E: w_hex_val = 4'hD;
            7'h79: w_hex_val = 4'hE;
            7'h71: w_hex_val = 4'hF;
            default: w_hex_ok = 1'b0;
        endcase
    end

    // Stability filter; last_acc updates on every commit, even when the event is dropped.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_cand     <= 8'h00;
            r_cnt      <= '0;
            r_last_acc <= 8'h00;
        end else begin
            if (seg_in != r_cand) begin
                r_cand <= seg_in;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_last_acc <= r_cand;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_handshake  = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_event) begin
                    w_load       = 1'b1;
                    w_next_state = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    w_handshake = 1'b1;
                    if (w_event) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = S_EMPTY;
                    end
                end else if (w_event) begin
                    w_drop = 1'b1;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_digit     <= 4'h0;
            r_dp        <= 1'b0;
            r_err       <= 1'b0;
            r_overrun   <= 1'b0;
            r_evt_count <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_digit <= w_hex_ok ? w_hex_val : 4'h0;
                r_dp    <= r_cand[7];
                r_err   <= !w_hex_ok;
            end
            if (w_handshake) begin
                r_evt_count <= r_evt_count + 8'h01;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign digit     = r_digit;
    assign dp        = r_dp;
    assign err       = r_err;
    assign overrun   = r_overrun;
    assign evt_count = r_evt_count;
endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - directed self-checking bench for seg7_reader
module tb_seg7_reader;
    logic       clk_2;
    logic       reset_n;
    logic [7:0] seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] digit;
    logic       dp;
    logic       err;
    logic       overrun;
    logic [7:0] evt_count;

    int total;
    int bad;
    int n;
    int seen;

    // Edges from the first sampling edge of a held pattern to out_valid: t0 plus STABLE_CYCLES.
    localparam int LAT = 5;

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .digit     (digit),
        .dp        (dp),
        .err       (err),
        .overrun   (overrun),
        .evt_count (evt_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] pat);
        seg_in  = pat;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, output int cnt);
        cnt = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (out_valid) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic hold_count(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (out_valid) hits++;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        seg_in    = 8'h00;
        out_ready = 1'b1;

        // 1: reset values, then 3F held decodes to 0
        out_ready = 1'b1;
        seg_in    = 8'h3F;
        reset_n   = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_digit", {28'd0, digit}, 32'd0);
        chk("rst_dp", {31'd0, dp}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_evt", {24'd0, evt_count}, 32'd0);
        reset_n = 1'b1;
        hold_count(LAT - 1, seen);
        chk("t1_early", seen, 0);
        step();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_digit", {28'd0, digit}, 32'd0);
        chk("t1_err", {31'd0, err}, 32'd0);
        step();
        chk("t1_drop", {31'd0, out_valid}, 32'd0);
        chk("t1_evt", {24'd0, evt_count}, 32'd1);

        // 2: 86 -> digit 1 with dp, no refire, glitch back to last_acc ignored
        do_reset(8'h00);
        seg_in = 8'h86;
        wait_valid(20, n);
        chk("t2_lat", n, LAT);
        chk("t2_digit", {28'd0, digit}, 32'd1);
        chk("t2_dp", {31'd0, dp}, 32'd1);
        chk("t2_err", {31'd0, err}, 32'd0);
        step();
        chk("t2_evt", {24'd0, evt_count}, 32'd1);
        hold_count(10, seen);
        chk("t2_norefire", seen, 0);
        seg_in = 8'h00;
        step();
        seg_in = 8'h86;
        hold_count(10, seen);
        chk("t2_glitch", seen, 0);
        chk("t2_evt_end", {24'd0, evt_count}, 32'd1);

        // 3: 06 too short, then 5B -> only digit 2
        do_reset(8'h00);
        seg_in = 8'h06;
        hold_count(3, seen);
        chk("t3_short", seen, 0);
        seg_in = 8'h5B;
        wait_valid(20, n);
        chk("t3_lat", n, LAT);
        chk("t3_digit", {28'd0, digit}, 32'd2);
        step();
        chk("t3_evt", {24'd0, evt_count}, 32'd1);

        // 4: invalid glyph 49, blank re-arms, 49 again
        do_reset(8'h00);
        seg_in = 8'h49;
        wait_valid(20, n);
        chk("t4_lat1", n, LAT);
        chk("t4_err1", {31'd0, err}, 32'd1);
        chk("t4_digit1", {28'd0, digit}, 32'd0);
        step();
        seg_in = 8'h00;
        hold_count(8, seen);
        chk("t4_blank", seen, 0);
        seg_in = 8'h49;
        wait_valid(20, n);
        chk("t4_lat2", n, LAT);
        chk("t4_err2", {31'd0, err}, 32'd1);
        step();
        chk("t4_evt", {24'd0, evt_count}, 32'd2);

        // 5: back-pressure, second event dropped with overrun
        do_reset(8'h00);
        out_ready = 1'b0;
        seg_in = 8'h7C;
        wait_valid(20, n);
        chk("t5_lat", n, LAT);
        chk("t5_digit_b", {28'd0, digit}, 32'd11);
        chk("t5_ovr_pre", {31'd0, overrun}, 32'd0);
        seg_in = 8'h39;
        hold_count(8, seen);
        chk("t5_held", seen, 8);
        chk("t5_digit_held", {28'd0, digit}, 32'd11);
        chk("t5_overrun", {31'd0, overrun}, 32'd1);
        chk("t5_evt_pre", {24'd0, evt_count}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("t5_valid_off", {31'd0, out_valid}, 32'd0);
        chk("t5_evt", {24'd0, evt_count}, 32'd1);
        hold_count(6, seen);
        chk("t5_c_lost", seen, 0);
        chk("t5_ovr_sticky", {31'd0, overrun}, 32'd1);

        // 6: reset mid-filtering discards partial 66
        do_reset(8'h00);
        seg_in = 8'h66;
        hold_count(2, seen);
        reset_n = 1'b0;
        step();
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        reset_n = 1'b1;
        wait_valid(20, n);
        chk("t6_lat", n, LAT);
        chk("t6_digit", {28'd0, digit}, 32'd4);
        step();
        chk("t6_evt", {24'd0, evt_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
